// File: rtl/controle_multiciclo.sv
// Multicycle control FSM for the RV64 subset datapath: sequences fetch through
// write-back, stalls on memory handshake, traps on illegal opcodes/timeouts.
module controle_multiciclo #(
  parameter int ALUFCT_W    = 3,
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [6:0]          opcode,
  input  logic [2:0]          funct3,
  input  logic [6:0]          funct7,
  input  logic                mem_ready,
  output logic [3:0]          state_out,
  output logic                mem_read,
  output logic                mem_write,
  output logic                ir_load,
  output logic                load_a,
  output logic                load_b,
  output logic                load_aluout,
  output logic                load_mdr,
  output logic                reg_write,
  output logic [1:0]          mem_to_reg,
  output logic [1:0]          alu_src_a,
  output logic [1:0]          alu_src_b,
  output logic [ALUFCT_W-1:0] alu_fct,
  output logic                pc_write,
  output logic [3:0]          pc_write_cond,
  output logic                pc_source,
  output logic                illegal_instr,
  output logic                mem_timeout,
  output logic [CNT_W-1:0]    instret
);

  typedef enum logic [3:0] {
    IDLE      = 4'd0,
    FETCH     = 4'd1,
    DECODE    = 4'd2,
    ADDR      = 4'd3,
    LOAD_MEM  = 4'd4,
    LOAD_WB   = 4'd5,
    STORE_MEM = 4'd6,
    EXEC_R    = 4'd7,
    EXEC_I    = 4'd8,
    ALU_WB    = 4'd9,
    BRANCH    = 4'd10,
    LUI_WB    = 4'd11,
    TRAP      = 4'd12
  } state_t;

  localparam logic [2:0] FCT_ADD = 3'b001;
  localparam logic [2:0] FCT_SUB = 3'b010;
  localparam logic [2:0] FCT_AND = 3'b011;
  localparam logic [2:0] FCT_SLT = 3'b111;

  localparam int            WC  = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WC-1:0] LIM = WC'(MEM_TIMEOUT - 1);

  state_t          state, state_next;
  logic [WC-1:0]   wait_cnt;
  logic [2:0]      fct_q;
  logic            store_q;
  logic [3:0]      cond_q;

  state_t          dec_next;
  logic [2:0]      dec_fct;
  logic            dec_store;
  logic [3:0]      dec_cond;
  logic            timeout_hit;
  logic            mem_state;
  logic            retire;

  // Instruction decode, consumed only while in DECODE
  always_comb begin
    dec_next  = TRAP;
    dec_fct   = FCT_ADD;
    dec_store = 1'b0;
    dec_cond  = 4'b0000;
    case (opcode)
      7'b0110011: begin
        if (funct7 == 7'b0000000) begin
          case (funct3)
            3'b000:  begin dec_next = EXEC_R; dec_fct = FCT_ADD; end
            3'b010:  begin dec_next = EXEC_R; dec_fct = FCT_SLT; end
            3'b111:  begin dec_next = EXEC_R; dec_fct = FCT_AND; end
            default: dec_next = TRAP;
          endcase
        end else if (funct7 == 7'b0100000 && funct3 == 3'b000) begin
          dec_next = EXEC_R;
          dec_fct  = FCT_SUB;
        end
      end
      7'b0010011: if (funct3 == 3'b000) dec_next = EXEC_I;
      7'b0000011: if (funct3 == 3'b011) dec_next = ADDR;
      7'b0100011: if (funct3 == 3'b011) begin dec_next = ADDR; dec_store = 1'b1; end
      7'b1100011: begin
        case (funct3)
          3'b000:  begin dec_next = BRANCH; dec_fct = FCT_SUB; dec_cond = 4'b0001; end
          3'b001:  begin dec_next = BRANCH; dec_fct = FCT_SUB; dec_cond = 4'b0010; end
          3'b101:  begin dec_next = BRANCH; dec_fct = FCT_SLT; dec_cond = 4'b0100; end
          3'b100:  begin dec_next = BRANCH; dec_fct = FCT_SLT; dec_cond = 4'b1000; end
          default: dec_next = TRAP;
        endcase
      end
      7'b0110111: dec_next = LUI_WB;
      default:    dec_next = TRAP;
    endcase
  end

  assign mem_state   = (state == FETCH) || (state == LOAD_MEM) || (state == STORE_MEM);
  assign timeout_hit = !mem_ready && (wait_cnt == LIM);
  assign retire      = (state_next == FETCH) &&
                       (state inside {ALU_WB, LOAD_WB, STORE_MEM, BRANCH, LUI_WB});

  always_comb begin
    state_next = state;
    case (state)
      IDLE:      state_next = FETCH;
      FETCH:     state_next = mem_ready ? DECODE : (timeout_hit ? TRAP : FETCH);
      DECODE:    state_next = dec_next;
      ADDR:      state_next = store_q ? STORE_MEM : LOAD_MEM;
      LOAD_MEM:  state_next = mem_ready ? LOAD_WB : (timeout_hit ? TRAP : LOAD_MEM);
      STORE_MEM: state_next = mem_ready ? FETCH : (timeout_hit ? TRAP : STORE_MEM);
      EXEC_R:    state_next = ALU_WB;
      EXEC_I:    state_next = ALU_WB;
      ALU_WB:    state_next = FETCH;
      LOAD_WB:   state_next = FETCH;
      BRANCH:    state_next = FETCH;
      LUI_WB:    state_next = FETCH;
      TRAP:      state_next = TRAP;
      default:   state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= IDLE;
      wait_cnt      <= '0;
      fct_q         <= 3'b000;
      store_q       <= 1'b0;
      cond_q        <= 4'b0000;
      illegal_instr <= 1'b0;
      mem_timeout   <= 1'b0;
      instret       <= '0;
    end else begin
      state <= state_next;
      // Wait counter restarts whenever a memory state is (re)entered
      if (state_next != state)
        wait_cnt <= '0;
      else if (mem_state && !mem_ready)
        wait_cnt <= wait_cnt + WC'(1);
      if (state == DECODE) begin
        fct_q   <= dec_fct;
        store_q <= dec_store;
        cond_q  <= dec_cond;
        if (dec_next == TRAP)
          illegal_instr <= 1'b1;
      end
      if (mem_state && timeout_hit)
        mem_timeout <= 1'b1;
      if (retire)
        instret <= instret + CNT_W'(1);
    end
  end

  assign state_out = state;

  always_comb begin
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_load       = 1'b0;
    load_a        = 1'b0;
    load_b        = 1'b0;
    load_aluout   = 1'b0;
    load_mdr      = 1'b0;
    reg_write     = 1'b0;
    mem_to_reg    = 2'b00;
    alu_src_a     = 2'b00;
    alu_src_b     = 2'b00;
    alu_fct       = '0;
    pc_write      = 1'b0;
    pc_write_cond = 4'b0000;
    pc_source     = 1'b0;
    case (state)
      FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        alu_fct   = ALUFCT_W'(FCT_ADD);
        ir_load   = mem_ready;
        pc_write  = mem_ready;
      end
      DECODE: begin
        alu_src_b   = 2'b11;
        alu_fct     = ALUFCT_W'(FCT_ADD);
        load_a      = 1'b1;
        load_b      = 1'b1;
        load_aluout = 1'b1;
      end
      EXEC_R: begin
        alu_src_a   = 2'b01;
        alu_src_b   = 2'b00;
        alu_fct     = ALUFCT_W'(fct_q);
        load_aluout = 1'b1;
      end
      EXEC_I, ADDR: begin
        alu_src_a   = 2'b01;
        alu_src_b   = 2'b10;
        alu_fct     = ALUFCT_W'(FCT_ADD);
        load_aluout = 1'b1;
      end
      ALU_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = 2'b00;
      end
      LOAD_MEM: begin
        mem_read = 1'b1;
        load_mdr = mem_ready;
      end
      LOAD_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = 2'b01;
      end
      STORE_MEM: mem_write = 1'b1;
      BRANCH: begin
        alu_src_a     = 2'b01;
        alu_src_b     = 2'b00;
        pc_source     = 1'b1;
        alu_fct       = ALUFCT_W'(fct_q);
        pc_write_cond = cond_q;
      end
      LUI_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = 2'b10;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_controle_multiciclo.sv
// Directed bench for controle_multiciclo (MEM_TIMEOUT=4, CNT_W=4).
module tb_controle_multiciclo;

  logic       clk = 1'b0;
  logic       reset;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic       mem_ready;
  logic [3:0] state_out;
  logic       mem_read, mem_write, ir_load, load_a, load_b, load_aluout, load_mdr, reg_write;
  logic [1:0] mem_to_reg, alu_src_a, alu_src_b;
  logic [2:0] alu_fct;
  logic       pc_write;
  logic [3:0] pc_write_cond;
  logic       pc_source;
  logic       illegal_instr, mem_timeout;
  logic [3:0] instret;
  logic [22:0] ctl;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  controle_multiciclo #(.ALUFCT_W(3), .MEM_TIMEOUT(4), .CNT_W(4)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .funct3(funct3), .funct7(funct7),
    .mem_ready(mem_ready), .state_out(state_out), .mem_read(mem_read),
    .mem_write(mem_write), .ir_load(ir_load), .load_a(load_a), .load_b(load_b),
    .load_aluout(load_aluout), .load_mdr(load_mdr), .reg_write(reg_write),
    .mem_to_reg(mem_to_reg), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .alu_fct(alu_fct), .pc_write(pc_write), .pc_write_cond(pc_write_cond),
    .pc_source(pc_source), .illegal_instr(illegal_instr), .mem_timeout(mem_timeout),
    .instret(instret)
  );

  assign ctl = {mem_read, mem_write, ir_load, load_a, load_b, load_aluout, load_mdr,
                reg_write, mem_to_reg, alu_src_a, alu_src_b, alu_fct, pc_write,
                pc_write_cond, pc_source};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  logic [2:0] bf3   [4] = '{3'b000, 3'b001, 3'b101, 3'b100};
  logic [3:0] bcond [4] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
  logic [2:0] bfct  [4] = '{3'b010, 3'b010, 3'b111, 3'b111};

  initial begin
    reset = 1'b0; opcode = '0; funct3 = '0; funct7 = '0; mem_ready = 1'b0;
    #2;
    chk("rst_state", state_out, 0);
    chk("rst_ctl", ctl, 0);
    chk("rst_instret", instret, 0);
    chk("rst_flags", {illegal_instr, mem_timeout}, 0);
    cyc();
    reset = 1'b1; #1;
    chk("idle_after_release", state_out, 0);
    cyc();
    chk("first_fetch", state_out, 1);

    // add
    opcode = 7'b0110011; funct3 = 3'b000; funct7 = 7'b0000000; mem_ready = 1'b1; #1;
    chk("fetch_mem_read", mem_read, 1);
    chk("fetch_ir_load", ir_load, 1);
    chk("fetch_pc_write", pc_write, 1);
    chk("fetch_src_b", alu_src_b, 2'b01);
    cyc(); chk("add_decode", state_out, 2);
    chk("decode_loads", {load_a, load_b, load_aluout}, 3'b111);
    chk("decode_src_b", alu_src_b, 2'b11);
    cyc(); chk("add_exec_r", state_out, 7);
    chk("add_fct", alu_fct, 3'b001);
    chk("add_src_a", alu_src_a, 2'b01);
    cyc(); chk("add_alu_wb", state_out, 9);
    chk("add_reg_write", reg_write, 1);
    chk("add_mem_to_reg", mem_to_reg, 2'b00);
    cyc(); chk("add_back_fetch", state_out, 1);
    chk("add_instret", instret, 1);

    // sub
    funct7 = 7'b0100000;
    cyc(); cyc();
    chk("sub_state", state_out, 7);
    chk("sub_fct", alu_fct, 3'b010);
    cyc(); cyc();
    chk("sub_instret", instret, 2);

    // ld with three memory waits
    opcode = 7'b0000011; funct3 = 3'b011; funct7 = '0;
    cyc(); cyc();
    chk("ld_addr", state_out, 3);
    chk("ld_addr_src_b", alu_src_b, 2'b10);
    mem_ready = 1'b0;
    cyc();
    for (int i = 0; i < 3; i++) begin
      chk("ld_wait_state", state_out, 4);
      chk("ld_wait_mdr", load_mdr, 0);
      chk("ld_wait_read", mem_read, 1);
      cyc();
    end
    mem_ready = 1'b1; #1;
    chk("ld_ready_state", state_out, 4);
    chk("ld_ready_mdr", load_mdr, 1);
    cyc(); chk("ld_wb", state_out, 5);
    chk("ld_wb_mem_to_reg", mem_to_reg, 2'b01);
    chk("ld_wb_reg_write", reg_write, 1);
    cyc(); chk("ld_back_fetch", state_out, 1);
    chk("ld_instret", instret, 3);

    // sd
    opcode = 7'b0100011; funct3 = 3'b011;
    cyc(); cyc(); cyc();
    chk("sd_store_mem", state_out, 6);
    chk("sd_mem_write", {mem_write, mem_read}, 2'b10);
    cyc(); chk("sd_back_fetch", state_out, 1);
    chk("sd_instret", instret, 4);

    // beq, bne, bge, blt
    opcode = 7'b1100011;
    for (int i = 0; i < 4; i++) begin
      funct3 = bf3[i];
      cyc(); cyc();
      chk("br_state", state_out, 10);
      chk("br_cond", pc_write_cond, bcond[i]);
      chk("br_fct", alu_fct, bfct[i]);
      chk("br_pc_source", pc_source, 1);
      cyc();
      chk("br_back_fetch", state_out, 1);
    end
    chk("br_instret", instret, 8);

    // fetch ready on the 4th cycle (boundary), then lui
    opcode = 7'b0110111; funct3 = '0; mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("fetch_wait_state", state_out, 1);
      chk("fetch_wait_read", {mem_read, ir_load}, 2'b10);
      cyc();
    end
    mem_ready = 1'b1; #1;
    chk("fetch_late_ir_load", ir_load, 1);
    cyc(); chk("fetch_late_decode", state_out, 2);
    cyc(); chk("lui_wb", state_out, 11);
    chk("lui_mem_to_reg", mem_to_reg, 2'b10);
    cyc(); chk("lui_instret", instret, 9);

    // illegal opcode
    opcode = 7'b1111111;
    cyc(); chk("ill_decode", state_out, 2);
    cyc(); chk("ill_trap", state_out, 12);
    chk("ill_flag", {illegal_instr, mem_timeout}, 2'b10);
    chk("ill_ctl", ctl, 0);
    for (int i = 0; i < 20; i++) begin
      cyc();
      chk("trap_hold", {state_out, illegal_instr, ctl}, {4'd12, 1'b1, 23'd0});
    end

    // asynchronous reset mid-run
    reset = 1'b0; #1;
    chk("mid_rst_state", state_out, 0);
    chk("mid_rst_instret", instret, 0);
    chk("mid_rst_flags", {illegal_instr, mem_timeout}, 0);
    cyc(); reset = 1'b1;
    cyc(); chk("mid_rst_fetch", state_out, 1);

    // 17 lui with 4-bit counter wraps to 1
    opcode = 7'b0110111; mem_ready = 1'b1;
    for (int i = 0; i < 17; i++) begin
      cyc(); cyc(); cyc();
    end
    chk("wrap_state", state_out, 1);
    chk("wrap_instret", instret, 1);

    // fetch timeout after 4 wait cycles
    mem_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("to_wait_state", state_out, 1);
      cyc();
    end
    chk("to_trap", state_out, 12);
    chk("to_flags", {illegal_instr, mem_timeout}, 2'b01);
    chk("to_ctl", ctl, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
